regfile_seq: RTL and testbench
==============================

# regfile_seq

Micro-sequencer that drives the 4 x 8-bit register file's read and write ports from a stream of small register instructions (load-immediate, move, add, subtract). It sits between an instruction source (switch/key front end or a future fetch unit) and the register file. It owns the register file's write port and both read-address ports. Instructions are accepted over a valid/ready handshake, and each completed write is reported with a one-cycle `done` pulse.

## Interface
- `DW`, 8: register data width.
- `AW`, 2: register address width (2^AW registers).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: sequencer can accept; high only in IDLE.
- `in_op` in 2: 00 MOVI, 01 MOV, 10 ADD, 11 SUB.
- `in_rd` in AW: destination register, also the first operand.
- `in_rs` in AW: source operand register.
- `in_imm` in 4: immediate for MOVI, sign-extended to DW.
- `rf_ra` out AW: register file read address A; always equals the latched rd.
- `rf_rb` out AW: register file read address B; always equals the latched rs.
- `rf_da` in DW: register file read data A (combinational from `rf_ra`).
- `rf_db` in DW: register file read data B (combinational from `rf_rb`).
- `rf_we` out 1: write enable; the write commits at the clock edge that ends the cycle.
- `rf_wa` out AW: write address.
- `rf_wd` out DW: write data.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse, coincident with `rf_we`.
- `flag_z`, `flag_n` out 1: zero and negative flags of the last written value (see Configuration).

## Operation
- States are IDLE, READ, EXEC and WRITE.
- **IDLE**
  - `in_ready=1`.
  - When `in_valid` is high at an edge, the sequencer latches op, rd, rs and imm.
  - MOVI goes to WRITE; every other op goes to READ.
- **READ**
  - `rf_ra`/`rf_rb` are stable from the latched fields.
  - At the end of the cycle, `rf_da` and `rf_db` are captured into operand registers A and B.
  - Goes to EXEC.
- **EXEC**
  - The result register is loaded as follows:
    - MOV: B.
    - ADD: (A+B) mod 2^DW.
    - SUB: (A−B) mod 2^DW.
  - Carry and borrow are discarded.
  - Goes to WRITE.
- **WRITE**
  - `rf_we=1`, `rf_wa`=latched rd, `done=1`.
  - `rf_wd` is the result register, or {{(DW−4){imm[3]}},imm} for MOVI.
  - Goes to IDLE unconditionally.
- Latched fields are held until the next accept. Changes on the `in_*` inputs while busy are ignored.
- `in_valid` while busy is not accepted; the source must hold it until `in_ready`.
- rd==rs is legal; operands are the same register (e.g. SUB rd,rd → 0).
- No result bypass is needed: the write commits before the next instruction's READ.
- Reset values:
  - State IDLE.
  - `in_ready=1`, `busy=0`, `rf_we=0`, `done=0`.
  - `rf_ra=rf_rb=rf_wa=0`, `rf_wd=0`.
  - `flag_z=0`, `flag_n=0`.
  - Operand and result registers 0.

## Timing
- Cycle 0 is the cycle in which `in_valid&in_ready` is sampled.
- MOVI: `rf_we`/`done` high in cycle 1; `in_ready` high again in cycle 2; throughput 1 instruction per 2 cycles.
- MOV/ADD/SUB: READ in cycle 1, EXEC in cycle 2, `rf_we`/`done` in cycle 3; `in_ready` again in cycle 4; throughput 1 per 4 cycles.
- `rf_we` is never high for more than one consecutive cycle.
- `rst_n` low at an edge in any state forces all reset values at that edge. If the sequencer is in WRITE at that edge, the write still reaches the register file only if the file samples `rf_we` at the same edge. The sequencer itself records no completion: flags stay at their reset value.
- `rst_n` low during READ or EXEC: no write is ever issued for that instruction.

## Configuration
- Macro: `REGFILE_SEQ_FLAGS_EN`.
- Defined:
  - `flag_z`/`flag_n` are registers updated at every edge where `rf_we=1`.
  - `flag_z=(rf_wd==0)`, `flag_n=rf_wd[DW−1]`.
  - They hold their value otherwise.
- Undefined: the ports remain present, tied to 0, and no flag storage is synthesised.

## Test plan
- Reset, then MOVI rd=2 imm=4'hA → cycle 1: `rf_we=1`, `rf_wa=2`, `rf_wd=8'hFA`, `done=1`; `in_ready=1` in cycle 2. With flags enabled: `flag_n=1`, `flag_z=0`.
- With the register file model holding R1=8'h7F, R2=8'h01, issue ADD rd=1 rs=2 → `rf_ra=1`, `rf_rb=2` during READ; cycle 3 `rf_wd=8'h80` to R1. With flags enabled: `flag_n=1`.
- R3=8'h05, SUB rd=3 rs=3 → `rf_wd=8'h00`. With flags enabled: `flag_z=1`, `flag_n=0`. Then R0=8'h01, SUB rd=0 rs=3 with R3=8'h02 → `rf_wd=8'hFF` (wrap).
- Hold `in_valid=1` with four back-to-back MOVs → exactly four accepts, `done` pulses 4 cycles apart, and `in_ready=0` in every busy cycle.
- ADD accepted, `rst_n` low in EXEC for one cycle → no `rf_we` pulse; all outputs at reset values; the next MOVI completes normally.
- Build without `REGFILE_SEQ_FLAGS_EN` and rerun the SUB-to-zero case → `flag_z=flag_n=0` throughout.

Source files
------------

// File: rtl/regfile_seq.sv
// regfile_seq: micro-sequencer driving a 4 x 8-bit register file.
// Takes MOVI/MOV/ADD/SUB instructions over a valid/ready handshake and
// owns the register file's read-address and write ports.
// Optional zero/negative flag registers: define REGFILE_SEQ_FLAGS_EN.
// When it is undefined the flag ports are tied to 0.

module regfile_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [3:0]    in_imm,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  input  logic [DW-1:0] rf_da,
  input  logic [DW-1:0] rf_db,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          busy,
  output logic          done,
  output logic          flag_z,
  output logic          flag_n
);

  localparam int unsigned IMM_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  logic [1:0]    state_q,  state_d;
  logic [1:0]    op_q,     op_d;
  logic [AW-1:0] rd_q,     rd_d;
  logic [AW-1:0] rs_q,     rs_d;
  logic [DW-1:0] a_q,      a_d;
  logic [DW-1:0] b_q,      b_d;
  logic [DW-1:0] result_q, result_d;
  logic          we_q,     we_d;
  logic          ready_q,  ready_d;
  logic          busy_q,   busy_d;

  // Next-state, operand capture and result computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    we_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          rd_d = in_rd;
          rs_d = in_rs;
          if (in_op == OP_MOVI) begin
            // MOVI skips READ/EXEC; the sign-extended immediate becomes the result.
            result_d = {{(DW-IMM_W){in_imm[IMM_W-1]}}, in_imm};
            state_d  = S_WRITE;
            we_d     = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        a_d     = rf_da;
        b_d     = rf_db;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_MOV:  result_d = b_q;
          OP_ADD:  result_d = DW'(a_q + b_q);
          OP_SUB:  result_d = DW'(a_q - b_q);
          default: result_d = result_q;
        endcase
        state_d = S_WRITE;
        we_d    = 1'b1;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MOVI;
      rd_q     <= '0;
      rs_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign rf_ra    = rd_q;
  assign rf_rb    = rs_q;
  assign rf_wa    = rd_q;
  assign rf_wd    = result_q;
  assign rf_we    = we_q;
  assign done     = we_q;

`ifdef REGFILE_SEQ_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  // Flags track the value committed by the most recent write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (we_q) begin
      flag_z_q <= (result_q == '0);
      flag_n_q <= result_q[DW-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq with a behavioural 4 x 8 register file.
// Flag expectations follow REGFILE_SEQ_FLAGS_EN when it is defined for the build.

module tb_regfile_seq;

`ifdef REGFILE_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs;
  logic [3:0] in_imm;
  logic [1:0] rf_ra, rf_rb, rf_wa;
  logic [7:0] rf_da, rf_db, rf_wd;
  logic       rf_we, busy, done, flag_z, flag_n;

  logic [7:0] rf_mem [4];

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_seq #(.DW(8), .AW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs    (in_rs),
    .in_imm   (in_imm),
    .rf_ra    (rf_ra),
    .rf_rb    (rf_rb),
    .rf_da    (rf_da),
    .rf_db    (rf_db),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .busy     (busy),
    .done     (done),
    .flag_z   (flag_z),
    .flag_n   (flag_n)
  );

  always #5 clk = ~clk;

  // Register file model: combinational reads, write at the clock edge.
  assign rf_da = rf_mem[rf_ra];
  assign rf_db = rf_mem[rf_rb];
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] r0, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] r3);
    rf_mem[0] = r0; rf_mem[1] = r1; rf_mem[2] = r2; rf_mem[3] = r3;
  endtask

  // Present one instruction for a single edge (sequencer must be idle), then scramble inputs.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [3:0] imm);
    in_op = op; in_rd = rd; in_rs = rs; in_imm = imm; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_op = OP_SUB; in_rd = ~rd; in_rs = ~rs; in_imm = ~imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_imm = '0;
    preload(8'h00, 8'h00, 8'h00, 8'h00);
    step(); step(); step();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0 || done !== 1'b0) $display("FAIL reset_we_done got=%b%b exp=00", rf_we, done); else pass_cnt++;
    total_cnt++; if ({rf_ra, rf_rb, rf_wa} !== 6'd0) $display("FAIL reset_addr got=%h exp=0", {rf_ra, rf_rb, rf_wa}); else pass_cnt++;
    total_cnt++; if (rf_wd !== 8'h00) $display("FAIL reset_wd got=%h exp=00", rf_wd); else pass_cnt++;
    total_cnt++; if ({flag_z, flag_n} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {flag_z, flag_n}); else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_movi();
    issue(OP_MOVI, 2'd2, 2'd0, 4'hA);
    total_cnt++; if (rf_we !== 1'b1 || done !== 1'b1) $display("FAIL movi_we_done got=%b%b exp=11", rf_we, done); else pass_cnt++;
    total_cnt++; if (rf_wa !== 2'd2) $display("FAIL movi_wa got=%0d exp=2", rf_wa); else pass_cnt++;
    total_cnt++; if (rf_wd !== 8'hFA) $display("FAIL movi_wd got=%h exp=fa", rf_wd); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL movi_busy got=%b%b exp=01", in_ready, busy); else pass_cnt++;
    step();
    total_cnt++; if (in_ready !== 1'b1 || rf_we !== 1'b0) $display("FAIL movi_ready2 got=%b%b exp=10", in_ready, rf_we); else pass_cnt++;
    total_cnt++; if (rf_mem[2] !== 8'hFA) $display("FAIL movi_commit got=%h exp=fa", rf_mem[2]); else pass_cnt++;
    total_cnt++; if ({flag_z, flag_n} !== {1'b0, FLAGS}) $display("FAIL movi_flags got=%b exp=%b", {flag_z, flag_n}, {1'b0, FLAGS}); else pass_cnt++;
  endtask

  task automatic test_add();
    preload(8'h00, 8'h7F, 8'h01, 8'h00);
    issue(OP_ADD, 2'd1, 2'd2, 4'h0);
    total_cnt++; if (rf_ra !== 2'd1 || rf_rb !== 2'd2) $display("FAIL add_read_addr got=%0d,%0d exp=1,2", rf_ra, rf_rb); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0 || busy !== 1'b1) $display("FAIL add_read_state got=%b%b exp=01", rf_we, busy); else pass_cnt++;
    step();
    total_cnt++; if (rf_we !== 1'b0 || in_ready !== 1'b0) $display("FAIL add_exec got=%b%b exp=00", rf_we, in_ready); else pass_cnt++;
    step();
    total_cnt++; if (rf_we !== 1'b1 || done !== 1'b1 || rf_wa !== 2'd1) $display("FAIL add_write got=%b%b wa=%0d exp=11 wa=1", rf_we, done, rf_wa); else pass_cnt++;
    total_cnt++; if (rf_wd !== 8'h80) $display("FAIL add_wd got=%h exp=80", rf_wd); else pass_cnt++;
    step();
    total_cnt++; if (in_ready !== 1'b1 || rf_mem[1] !== 8'h80) $display("FAIL add_commit got=%b,%h exp=1,80", in_ready, rf_mem[1]); else pass_cnt++;
    total_cnt++; if ({flag_z, flag_n} !== {1'b0, FLAGS}) $display("FAIL add_flags got=%b exp=%b", {flag_z, flag_n}, {1'b0, FLAGS}); else pass_cnt++;
  endtask

  task automatic test_sub();
    preload(8'h00, 8'h00, 8'h00, 8'h05);
    issue(OP_SUB, 2'd3, 2'd3, 4'h0);
    step(); step();
    total_cnt++; if (rf_we !== 1'b1 || rf_wd !== 8'h00 || rf_wa !== 2'd3) $display("FAIL sub_zero got=%b,%h,%0d exp=1,00,3", rf_we, rf_wd, rf_wa); else pass_cnt++;
    step();
    total_cnt++; if ({flag_z, flag_n} !== {FLAGS, 1'b0}) $display("FAIL sub_zero_flags got=%b exp=%b", {flag_z, flag_n}, {FLAGS, 1'b0}); else pass_cnt++;
    preload(8'h01, 8'h00, 8'h00, 8'h02);
    issue(OP_SUB, 2'd0, 2'd3, 4'h0);
    step(); step();
    total_cnt++; if (rf_we !== 1'b1 || rf_wd !== 8'hFF || rf_wa !== 2'd0) $display("FAIL sub_wrap got=%b,%h,%0d exp=1,ff,0", rf_we, rf_wd, rf_wa); else pass_cnt++;
    step();
    total_cnt++; if ({flag_z, flag_n} !== {1'b0, FLAGS}) $display("FAIL sub_wrap_flags got=%b exp=%b", {flag_z, flag_n}, {1'b0, FLAGS}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] rds [4];
    logic [1:0] rss [4];
    logic [7:0] exp_wd [4];
    int idx, accepts, dones, last_done;
    logic accept, prev_we;
    rds = '{2'd0, 2'd1, 2'd2, 2'd3};
    rss = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_wd = '{8'h22, 8'h33, 8'h44, 8'h22};
    preload(8'h11, 8'h22, 8'h33, 8'h44);
    idx = 0; accepts = 0; dones = 0; last_done = -1; prev_we = 1'b0;
    in_op = OP_MOV; in_rd = rds[0]; in_rs = rss[0]; in_imm = 4'h0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      accept = in_valid & in_ready;
      step();
      if (accept) begin
        accepts++;
        idx++;
        if (idx < 4) begin in_rd = rds[idx]; in_rs = rss[idx]; end
        else in_valid = 1'b0;
      end
      if (busy === 1'b1) begin
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_busy cyc=%0d got=%b exp=0", cyc, in_ready); else pass_cnt++;
      end
      if (rf_we === 1'b1) begin
        total_cnt++; if (prev_we !== 1'b0) $display("FAIL b2b_we_consec cyc=%0d got=1 exp=0", cyc); else pass_cnt++;
        if (dones < 4) begin
          total_cnt++; if (rf_wd !== exp_wd[dones]) $display("FAIL b2b_wd n=%0d got=%h exp=%h", dones, rf_wd, exp_wd[dones]); else pass_cnt++;
        end
        if (last_done >= 0) begin
          total_cnt++; if (cyc - last_done != 4) $display("FAIL b2b_spacing got=%0d exp=4", cyc - last_done); else pass_cnt++;
        end
        last_done = cyc;
        dones++;
      end
      prev_we = rf_we;
    end
    total_cnt++; if (accepts != 4) $display("FAIL b2b_accepts got=%0d exp=4", accepts); else pass_cnt++;
    total_cnt++; if (dones != 4) $display("FAIL b2b_dones got=%0d exp=4", dones); else pass_cnt++;
    total_cnt++; if ({rf_mem[0], rf_mem[1], rf_mem[2], rf_mem[3]} !== 32'h22334422)
      $display("FAIL b2b_regs got=%h exp=22334422", {rf_mem[0], rf_mem[1], rf_mem[2], rf_mem[3]}); else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    int we_seen;
    preload(8'h10, 8'h20, 8'h30, 8'h40);
    issue(OP_ADD, 2'd1, 2'd2, 4'h0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++; if (rf_we !== 1'b0 || done !== 1'b0) $display("FAIL rexec_we got=%b%b exp=00", rf_we, done); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rexec_ready got=%b%b exp=10", in_ready, busy); else pass_cnt++;
    total_cnt++; if ({rf_ra, rf_rb, rf_wa} !== 6'd0 || rf_wd !== 8'h00) $display("FAIL rexec_outs got=%h,%h exp=0,00", {rf_ra, rf_rb, rf_wa}, rf_wd); else pass_cnt++;
    total_cnt++; if ({flag_z, flag_n} !== 2'b00) $display("FAIL rexec_flags got=%b exp=00", {flag_z, flag_n}); else pass_cnt++;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_we === 1'b1) we_seen++;
    end
    total_cnt++; if (we_seen != 0 || rf_mem[1] !== 8'h20) $display("FAIL rexec_no_write got=%0d,%h exp=0,20", we_seen, rf_mem[1]); else pass_cnt++;
    issue(OP_MOVI, 2'd1, 2'd0, 4'h3);
    total_cnt++; if (rf_we !== 1'b1 || rf_wd !== 8'h03 || rf_wa !== 2'd1) $display("FAIL rexec_movi got=%b,%h,%0d exp=1,03,1", rf_we, rf_wd, rf_wa); else pass_cnt++;
    step();
    total_cnt++; if (rf_mem[1] !== 8'h03 || in_ready !== 1'b1) $display("FAIL rexec_movi_commit got=%h,%b exp=03,1", rf_mem[1], in_ready); else pass_cnt++;
    total_cnt++; if ({flag_z, flag_n} !== 2'b00) $display("FAIL rexec_movi_flags got=%b exp=00", {flag_z, flag_n}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_movi();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_exec();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
